// File: rtl/sim_intf_arb.sv
// Round-robin arbiter sharing one sim_intf lookup port among NREQ requesters.
// Each lookup runs IDLE -> ISSUE -> WAIT(LATENCY) -> RESP.
module sim_intf_arb #(
    parameter int NREQ    = 2,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*64-1:0] req_pc,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    input  logic [NREQ-1:0]    rsp_ready,
    output logic [63:0]        rsp_pc_factual,
    output logic [31:0]        rsp_inst,
    output logic               rsp_miss,
    output logic [63:0]        sim_pc_try,
    input  logic [63:0]        sim_pc_factual,
    input  logic [31:0]        sim_inst,
    input  logic               sim_miss,
    output logic               busy,
    output logic [31:0]        miss_cnt
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t         state;
    logic [IW-1:0]  grant_q;
    logic [IW-1:0]  last_grant;
    logic [IW-1:0]  gnt;
    logic [IW-1:0]  idx;
    logic           gnt_found;
    logic [63:0]    pc_q;
    logic [3:0]     cnt;
    logic [NREQ-1:0] one;

    assign one = {{(NREQ-1){1'b0}}, 1'b1};

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        gnt       = '0;
        gnt_found = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(last_grant) + k) % NREQ);
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt       = idx;
            end
        end
    end

    assign req_ready  = (state == IDLE && gnt_found) ? (one << gnt) : '0;
    assign sim_pc_try = pc_q;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            pc_q           <= '0;
            grant_q        <= '0;
            last_grant     <= IW'(NREQ - 1);
            cnt            <= '0;
            rsp_valid      <= '0;
            rsp_pc_factual <= '0;
            rsp_inst       <= '0;
            rsp_miss       <= 1'b0;
            miss_cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt_found) begin
                        pc_q       <= req_pc[64*gnt +: 64];
                        grant_q    <= gnt;
                        last_grant <= gnt;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= 4'(LATENCY);
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        cnt            <= '0;
                        rsp_pc_factual <= sim_pc_factual;
                        rsp_inst       <= sim_inst;
                        rsp_miss       <= sim_miss;
                        rsp_valid      <= one << grant_q;
                        if (sim_miss && miss_cnt != '1)
                            miss_cnt <= miss_cnt + 32'd1;
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready[grant_q]) begin
                        rsp_valid <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sim_intf_arb.sv
// Bench for sim_intf_arb: LATENCY=1 instance with a response scoreboard,
// plus a LATENCY=3 instance for timing.
module tb_sim_intf_arb;

    logic         clk;
    logic         rst;

    logic [1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [127:0] req_pc;
    logic [63:0]  rsp_pc_factual, sim_pc_try, sim_pc_factual;
    logic [31:0]  rsp_inst, sim_inst, miss_cnt;
    logic         rsp_miss, sim_miss, busy;

    logic [1:0]   req_valid3, req_ready3, rsp_valid3, rsp_ready3;
    logic [127:0] req_pc3;
    logic [63:0]  rsp_pc_factual3, sim_pc_try3, sim_pc_factual3;
    logic [31:0]  rsp_inst3, sim_inst3, miss_cnt3;
    logic         rsp_miss3, sim_miss3, busy3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  vld;
        logic [63:0] pc;
        logic [31:0] inst;
        logic        miss;
    } exp_t;

    exp_t sb[$];

    // Model of the simulator lookup port.
    function automatic logic [63:0] m_fact(input logic [63:0] pc);
        return pc & 64'hFFFF;
    endfunction

    function automatic logic [31:0] m_inst(input logic [63:0] pc);
        return 32'h297 ^ {16'h0, pc[15:0]} ^ 32'h1000;
    endfunction

    function automatic logic m_miss(input logic [63:0] pc);
        return pc[31:16] != 16'h0;
    endfunction

    function automatic void push(input int g, input logic [63:0] pc);
        exp_t e;
        e.vld  = 2'b01 << g;
        e.pc   = m_fact(pc);
        e.inst = m_inst(pc);
        e.miss = m_miss(pc);
        sb.push_back(e);
    endfunction

    assign sim_pc_factual  = m_fact(sim_pc_try);
    assign sim_inst        = m_inst(sim_pc_try);
    assign sim_miss        = m_miss(sim_pc_try);
    assign sim_pc_factual3 = m_fact(sim_pc_try3);
    assign sim_inst3       = m_inst(sim_pc_try3);
    assign sim_miss3       = m_miss(sim_pc_try3);

    sim_intf_arb #(.NREQ(2), .LATENCY(1)) u1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_pc(req_pc), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_pc_factual(rsp_pc_factual), .rsp_inst(rsp_inst),
        .rsp_miss(rsp_miss), .sim_pc_try(sim_pc_try),
        .sim_pc_factual(sim_pc_factual), .sim_inst(sim_inst),
        .sim_miss(sim_miss), .busy(busy), .miss_cnt(miss_cnt)
    );

    sim_intf_arb #(.NREQ(2), .LATENCY(3)) u3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid3), .req_pc(req_pc3), .req_ready(req_ready3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_pc_factual(rsp_pc_factual3), .rsp_inst(rsp_inst3),
        .rsp_miss(rsp_miss3), .sim_pc_try(sim_pc_try3),
        .sim_pc_factual(sim_pc_factual3), .sim_inst(sim_inst3),
        .sim_miss(sim_miss3), .busy(busy3), .miss_cnt(miss_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: pop on the first cycle of each response.
    logic [1:0] prev_v = 2'b00;
    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid != 2'b00 && prev_v == 2'b00) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: rsp_valid=%b, none expected",
                         rsp_valid);
            end else begin
                e = sb.pop_front();
                if (rsp_valid !== e.vld || rsp_pc_factual !== e.pc ||
                    rsp_inst !== e.inst || rsp_miss !== e.miss) begin
                    errors++;
                    $display("FAIL sb_rsp: got %b/%h/%h/%b want %b/%h/%h/%b",
                             rsp_valid, rsp_pc_factual, rsp_inst, rsp_miss,
                             e.vld, e.pc, e.inst, e.miss);
                end
            end
        end
        prev_v <= rsp_valid;
    end

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0; req_pc = '0; rsp_ready = 2'b11;
        req_valid3 = '0; req_pc3 = '0; rsp_ready3 = 2'b11;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({busy, rsp_valid, req_ready, rsp_miss} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctl: got %b want 0",
                     {busy, rsp_valid, req_ready, rsp_miss});
        end
        checks++;
        if ({sim_pc_try, rsp_pc_factual, rsp_inst, miss_cnt} !== 192'b0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h %h want 0",
                     sim_pc_try, rsp_pc_factual, rsp_inst, miss_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_hit();
        @(negedge clk);
        req_valid = 2'b01;
        req_pc[63:0] = 64'h1000;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL hit_ready: got %b want 01", req_ready);
        end
        push(0, 64'h1000);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        checks++;
        if (sim_pc_try !== 64'h1000 || busy !== 1'b1 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL hit_t1: pc=%h busy=%b rdy=%b want 1000/1/00",
                     sim_pc_try, busy, req_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (sim_pc_try !== 64'h1000 || rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL hit_t2: pc=%h rv=%b want 1000/00",
                     sim_pc_try, rsp_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 2'b01 || rsp_pc_factual !== 64'h1000 ||
            rsp_inst !== 32'h00000297 || rsp_miss !== 1'b0 ||
            miss_cnt !== 32'd0) begin
            errors++;
            $display("FAIL hit_t3: %b/%h/%h/%b/%0d want 01/1000/00000297/0/0",
                     rsp_valid, rsp_pc_factual, rsp_inst, rsp_miss, miss_cnt);
        end
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL hit_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_miss();
        @(negedge clk);
        req_valid = 2'b10;
        req_pc[127:64] = 64'hAAAA1008;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL miss_ready: got %b want 10", req_ready);
        end
        push(1, 64'hAAAA1008);
        @(negedge clk);
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 2'b10 || rsp_pc_factual !== 64'h1008 ||
            rsp_miss !== 1'b1 || miss_cnt !== 32'd1) begin
            errors++;
            $display("FAIL miss_rsp: %b/%h/%b/%0d want 10/1008/1/1",
                     rsp_valid, rsp_pc_factual, rsp_miss, miss_cnt);
        end
        @(negedge clk);
    endtask

    task automatic test_contention();
        int k = 0;
        int last_acc = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req_pc = {64'h3004, 64'h2000};
        req_valid = 2'b11;
        for (int c = 0; c < 40 && k < 4; c++) begin
            #1;
            if (req_ready != 2'b00) begin
                checks++;
                if (req_ready !== (2'b01 << (k % 2))) begin
                    errors++;
                    $display("FAIL grant_order: #%0d got %b want %b",
                             k, req_ready, 2'b01 << (k % 2));
                end
                if (k > 0) begin
                    checks++;
                    if (c - last_acc != 4) begin
                        errors++;
                        $display("FAIL throughput: got %0d cycles want 4",
                                 c - last_acc);
                    end
                end
                push(k % 2, (k % 2 == 1) ? 64'h3004 : 64'h2000);
                last_acc = c;
                k++;
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        checks++;
        if (k != 4) begin
            errors++;
            $display("FAIL contention_timeout: got %0d grants want 4", k);
        end
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL contention_drain: busy=%b pending=%0d want 0/0",
                     busy, sb.size());
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        rsp_ready = 2'b00;
        req_valid = 2'b01;
        req_pc[63:0] = 64'h4000;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL bp_ready: got %b want 01", req_ready);
        end
        push(0, 64'h4000);
        @(negedge clk);
        req_valid = 2'b10;
        req_pc[127:64] = 64'h5008;
        repeat (2) begin
            #1;
            checks++;
            if (req_ready !== 2'b00) begin
                errors++;
                $display("FAIL bp_busy_ready: got %b want 00", req_ready);
            end
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            rsp_ready = 2'b10;
            #1;
            checks++;
            if (rsp_valid !== 2'b01 || rsp_pc_factual !== 64'h4000 ||
                rsp_inst !== m_inst(64'h4000) || req_ready !== 2'b00 ||
                busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold: c%0d %b/%h/%h rdy=%b busy=%b",
                         i, rsp_valid, rsp_pc_factual, rsp_inst,
                         req_ready, busy);
            end
            @(negedge clk);
        end
        rsp_ready = 2'b01;
        #1;
        checks++;
        if (rsp_valid !== 2'b01) begin
            errors++;
            $display("FAIL bp_pre_accept: got %b want 01", rsp_valid);
        end
        @(negedge clk);
        rsp_ready = 2'b11;
        #1;
        checks++;
        if (rsp_valid !== 2'b00 || req_ready !== 2'b10) begin
            errors++;
            $display("FAIL bp_release: rv=%b rdy=%b want 00/10",
                     rsp_valid, req_ready);
        end
        push(1, 64'h5008);
        @(negedge clk);
        req_valid = 2'b00;
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: busy=%b pending=%0d want 0/0",
                     busy, sb.size());
        end
    endtask

    task automatic test_reset_wait();
        int n = 0;
        @(negedge clk);
        req_valid = 2'b01;
        req_pc[63:0] = 64'hBBBB0000;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rw_ready: got %b want 01", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, rsp_valid, req_ready, rsp_miss} !== 6'b0 ||
            sim_pc_try !== 64'h0 || miss_cnt !== 32'd0 ||
            rsp_pc_factual !== 64'h0 || rsp_inst !== 32'h0) begin
            errors++;
            $display("FAIL rw_reset: busy=%b rv=%b pc=%h mc=%0d want all 0",
                     busy, rsp_valid, sim_pc_try, miss_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #1;
            checks++;
            if (rsp_valid !== 2'b00 || miss_cnt !== 32'd0) begin
                errors++;
                $display("FAIL rw_discard: rv=%b mc=%0d want 00/0",
                         rsp_valid, miss_cnt);
            end
        end
        @(negedge clk);
        req_valid = 2'b10;
        req_pc[127:64] = 64'h7010;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            errors++;
            $display("FAIL rw_req1: got %b want 10", req_ready);
        end
        push(1, 64'h7010);
        @(negedge clk);
        req_valid = 2'b00;
        n = 1;
        while (n < 12 && rsp_valid == 2'b00) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL rw_latency: got %0d cycles want 3", n);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_latency3();
        @(negedge clk);
        req_valid3 = 2'b01;
        req_pc3[63:0] = 64'h1000;
        #1;
        checks++;
        if (req_ready3 !== 2'b01) begin
            errors++;
            $display("FAIL l3_ready: got %b want 01", req_ready3);
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            req_valid3 = 2'b00;
            #1;
            checks++;
            if (sim_pc_try3 !== 64'h1000 || rsp_valid3 !== 2'b00 ||
                busy3 !== 1'b1) begin
                errors++;
                $display("FAIL l3_wait: c%0d pc=%h rv=%b busy=%b",
                         k, sim_pc_try3, rsp_valid3, busy3);
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid3 !== 2'b01 || rsp_pc_factual3 !== 64'h1000 ||
            rsp_inst3 !== 32'h00000297 || rsp_miss3 !== 1'b0) begin
            errors++;
            $display("FAIL l3_rsp: %b/%h/%h/%b want 01/1000/00000297/0",
                     rsp_valid3, rsp_pc_factual3, rsp_inst3, rsp_miss3);
        end
        @(negedge clk);
        #1;
        checks++;
        if (busy3 !== 1'b0) begin
            errors++;
            $display("FAIL l3_idle: busy=%b want 0", busy3);
        end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_miss();
        test_contention();
        test_backpressure();
        test_reset_wait();
        test_latency3();
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
